sram_sp_4096x16: RTL and testbench

- Synchronous single-port SRAM, 4096 words × 16 bits, behavioural model of the SHAB90_4096X16X1CM16 macro.
- Used by the kMeans engine as the point buffer.
  - Write phase: 4096 packed {x[15:8], y[7:0]} samples stored at sequential addresses.
  - Clustering phase: samples re-read once per iteration.
- One clock, one access per cycle.
- Read and write share the single address port.

---
 rtl/sram_sp_4096x16_pkg.sv | 34 +++
 rtl/sram_sp_4096x16.sv | 64 ++++++
 tb/tb_sram_sp_4096x16.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sram_sp_4096x16_pkg.sv
// Purpose : shared constants and types for the kMeans point buffer SRAM.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// A stored point is packed as {x[15:8], y[7:0]}; the slice constants and
// helpers below keep producers and consumers agreeing on that layout.
package sram_sp_4096x16_pkg;

  localparam int MEM_ADDR_W = 12;
  localparam int MEM_DATA_W = 16;
  localparam int MEM_DEPTH  = 4096;

  typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
  typedef logic [MEM_DATA_W-1:0] mem_word_t;

  // Point-field slices within a memory word.
  localparam int PT_X_HI = 15;
  localparam int PT_X_LO = 8;
  localparam int PT_Y_HI = 7;
  localparam int PT_Y_LO = 0;

  function automatic mem_word_t pt_pack(input logic [7:0] x, input logic [7:0] y);
    return {x, y};
  endfunction

  function automatic logic [7:0] pt_x(input mem_word_t w);
    return w[PT_X_HI:PT_X_LO];
  endfunction

  function automatic logic [7:0] pt_y(input mem_word_t w);
    return w[PT_Y_HI:PT_Y_LO];
  endfunction

endpackage

// File: rtl/sram_sp_4096x16.sv
// Purpose : behavioural single-port 4096x16 synchronous SRAM (SHAB90_4096X16X1CM16 model).
// Latency : 1 cycle address-edge to DO; writes are written through to DO.
// Backpressure: none; one access per cycle is always accepted when CS=1.
//
// Ports:
//   clk   - clock, all accesses on the rising edge
//   rst_n - async active-low reset; clears the DO register only, never the array
//   A     - word address (shared by reads and writes)
//   DI    - write data
//   DO    - read data, registered, forced to 0 when OE=0
//   WEB   - write enable, active low (0 = write, 1 = read)
//   OE    - output enable, active high, purely combinational on DO
//   CS    - chip select, active high; CS=0 means no access and DO holds
module sram_sp_4096x16
  import sram_sp_4096x16_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int DEPTH  = MEM_DEPTH    // must equal 2**ADDR_W, so A is always in range
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] DI,
  output logic [DATA_W-1:0] DO,
  input  logic              WEB,
  input  logic              OE,
  input  logic              CS
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_do;
  logic              w_wr;
  logic              w_rd;

  assign w_wr = CS & ~WEB;
  assign w_rd = CS &  WEB;

  // The array has no reset: contents survive rst_n, and never-written words
  // stay X in simulation. rst_n is sampled as a write qualifier so an edge
  // that lands while reset is asserted cannot corrupt the array.
  always_ff @(posedge clk) begin
    if (rst_n && w_wr) begin
      r_mem[A] <= DI;
    end
  end

  // Output register. A write loads DI directly, which also makes a read of
  // the just-written address on the following cycle see the new data
  // (the array itself is already updated by then).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_do <= '0;
    end else if (w_wr) begin
      r_do <= DI;
    end else if (w_rd) begin
      r_do <= r_mem[A];
    end
  end

  // OE only masks the pin; it never blocks an access.
  assign DO = OE ? r_do : '0;

endmodule

// File: tb/tb_sram_sp_4096x16.sv
module tb_sram_sp_4096x16;
  import sram_sp_4096x16_pkg::*;

  logic      clk;
  logic      rst_n;
  mem_addr_t A;
  mem_word_t DI;
  mem_word_t DO;
  logic      WEB;
  logic      OE;
  logic      CS;

  int errors = 0;
  int checks = 0;

  mem_word_t exp_q[$];

  sram_sp_4096x16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .DI    (DI),
    .DO    (DO),
    .WEB   (WEB),
    .OE    (OE),
    .CS    (CS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic      rst_n;
    logic      cs;
    logic      web;
    logic      oe;
    mem_addr_t a;
    mem_word_t di;
    mem_word_t exp;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic r, input logic c, input logic w, input logic o,
                              input mem_addr_t a, input mem_word_t d, input mem_word_t e);
    vec_t v;
    v.rst_n = r; v.cs = c; v.web = w; v.oe = o; v.a = a; v.di = d; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input mem_word_t act, input mem_word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: DO=%h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, push the expected DO, then pop and compare 1ns after the edge.
  task automatic cycle(input string name, input logic r, input logic c, input logic w,
                       input logic o, input mem_addr_t a, input mem_word_t d,
                       input mem_word_t e);
    mem_word_t exp;
    rst_n = r; CS = c; WEB = w; OE = o; A = a; DI = d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check(name, DO, exp);
  endtask

  function automatic mem_word_t sweep_word(input int i);
    mem_addr_t ia;
    ia = mem_addr_t'(i);
    return {ia[7:0], ~ia[7:0]};
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; CS = 1'b1; WEB = 1'b1; OE = 1'b1; A = '0; DI = '0;

    //             rst cs web oe  A       DI         expected DO
    vecs[0]  = mk(0, 1, 1, 1, 12'd0,    16'h0000, 16'h0000); // held in reset
    vecs[1]  = mk(1, 0, 1, 1, 12'd0,    16'h0000, 16'h0000); // released, no access
    vecs[2]  = mk(1, 1, 0, 1, 12'd0,    16'h1234, 16'h1234); // write-through
    vecs[3]  = mk(1, 1, 0, 1, 12'd4095, 16'hABCD, 16'hABCD);
    vecs[4]  = mk(1, 1, 0, 1, 12'd2048, 16'h00FF, 16'h00FF);
    vecs[5]  = mk(1, 1, 1, 1, 12'd0,    16'h0000, 16'h1234); // readback
    vecs[6]  = mk(1, 1, 1, 1, 12'd4095, 16'h0000, 16'hABCD);
    vecs[7]  = mk(1, 1, 1, 1, 12'd2048, 16'h0000, 16'h00FF);
    vecs[8]  = mk(1, 1, 0, 1, 12'd7,    16'h5A5A, 16'h5A5A); // write A=7
    vecs[9]  = mk(1, 1, 1, 1, 12'd7,    16'h0000, 16'h5A5A); // read-after-write
    vecs[10] = mk(1, 0, 0, 1, 12'd7,    16'hFFFF, 16'h5A5A); // CS=0 write ignored, DO holds
    vecs[11] = mk(1, 1, 1, 1, 12'd0,    16'h0000, 16'h1234);
    vecs[12] = mk(1, 1, 1, 1, 12'd7,    16'h0000, 16'h5A5A); // mem[7] untouched
    vecs[13] = mk(1, 0, 1, 0, 12'd0,    16'h0000, 16'h0000); // OE=0 masks
    vecs[14] = mk(1, 0, 1, 1, 12'd0,    16'h0000, 16'h5A5A); // OE=1 restores
    vecs[15] = mk(1, 1, 1, 0, 12'd4095, 16'h0000, 16'h0000); // read while masked
    vecs[16] = mk(1, 0, 1, 1, 12'd0,    16'h0000, 16'hABCD); // OE does not gate access
    vecs[17] = mk(0, 1, 0, 1, 12'd0,    16'hDEAD, 16'h0000); // write during reset dropped
    vecs[18] = mk(1, 1, 1, 1, 12'd0,    16'h0000, 16'h1234); // contents kept
    vecs[19] = mk(1, 1, 1, 1, 12'd2048, 16'h0000, 16'h00FF);
    vecs[20] = mk(1, 0, 1, 1, 12'd5,    16'h0000, 16'h00FF); // idle holds

    #1;
    check("reset_async", DO, 16'h0000);

    for (int i = 0; i < NV; i++) begin
      cycle($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].cs, vecs[i].web, vecs[i].oe,
            vecs[i].a, vecs[i].di, vecs[i].exp);
    end

    // OE is combinational: flip it with no clock edge in between.
    #2;
    OE = 1'b0;
    #1;
    check("oe_comb_off", DO, 16'h0000);
    OE = 1'b1;
    #1;
    check("oe_comb_on", DO, 16'h00FF);

    // Full sweep: write every word, then read it all back with no gaps.
    for (int i = 0; i < MEM_DEPTH; i++) begin
      cycle("sweep_wr", 1'b1, 1'b1, 1'b0, 1'b1, mem_addr_t'(i), sweep_word(i), sweep_word(i));
    end
    for (int i = 0; i < MEM_DEPTH; i++) begin
      cycle($sformatf("sweep_rd%0d", i), 1'b1, 1'b1, 1'b1, 1'b1, mem_addr_t'(i),
            16'h0000, sweep_word(i));
    end

    // Reset mid-stream during a read sweep.
    for (int i = 100; i < 110; i++) begin
      cycle("mid_rd", 1'b1, 1'b1, 1'b1, 1'b1, mem_addr_t'(i), 16'h0000, sweep_word(i));
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_drop", DO, 16'h0000);
    cycle("mid_reset_wr", 1'b0, 1'b1, 1'b0, 1'b1, 12'd4095, 16'h1111, 16'h0000);
    cycle("post_reset_idle", 1'b1, 1'b0, 1'b1, 1'b1, 12'd0, 16'h0000, 16'h0000);
    cycle("post_reset_4095", 1'b1, 1'b1, 1'b1, 1'b1, 12'd4095, 16'h0000, sweep_word(4095));
    cycle("post_reset_110", 1'b1, 1'b1, 1'b1, 1'b1, 12'd110, 16'h0000, sweep_word(110));

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
